// File: rtl/m_shiftpkg.sv
// Shared definitions for the midgetv shift sequencers.
//
// Contents:
//   SH_LOAD / SH_LDBYTE / SH_ADV / SH_HOLD : s_shift operation encodings.
//   ByteShift : left-shift applied to a byte offset to turn it into a bit
//               distance (one byte = 8 bits).
//   sh_op_e   : enum view of the operation code for debugging and decode.
package m_shiftpkg;

  localparam logic [1:0] SH_LOAD   = 2'b00;
  localparam logic [1:0] SH_LDBYTE = 2'b01;
  localparam logic [1:0] SH_ADV    = 2'b10;
  localparam logic [1:0] SH_HOLD   = 2'b11;

  localparam int unsigned ByteShift = 3;

  typedef enum logic [1:0] {
    OpLoad   = SH_LOAD,
    OpLdByte = SH_LDBYTE,
    OpAdv    = SH_ADV,
    OpHold   = SH_HOLD
  } sh_op_e;

endpackage

// File: rtl/m_shiftcounter_p_if.sv
// Microcode <-> shift counter signal bundle.
//
// Signals:
//   s_shift    : operation code (see m_shiftpkg).
//   B          : load source, CNTW bits.
//   busy       : remaining count is non-zero.
//   coarse     : current step is a coarse (2^CSTEP) step.
//   lastshift  : the advance issued this cycle consumes the remaining count.
//   uflow      : sticky, an advance was issued with nothing left to shift.
//   dbg_rshcnt : remaining count, for debug visibility.
//
// Modports:
//   master : microcode sequencer side (drives op and operand).
//   slave  : shift counter side.
interface m_shiftcounter_p_if #(
  parameter int unsigned CNTW = 5
) ();

  logic [1:0]      s_shift;
  logic [CNTW-1:0] B;
  logic            busy;
  logic            coarse;
  logic            lastshift;
  logic            uflow;
  logic [CNTW-1:0] dbg_rshcnt;

  modport master (
    output s_shift,
    output B,
    input  busy,
    input  coarse,
    input  lastshift,
    input  uflow,
    input  dbg_rshcnt
  );

  modport slave (
    input  s_shift,
    input  B,
    output busy,
    output coarse,
    output lastshift,
    output uflow,
    output dbg_rshcnt
  );

endinterface

// File: rtl/m_shiftstep.sv
// Step-size decode for a remaining-distance counter. Purely combinational.
//
// Given the current count, decides whether the next step may be a coarse
// step of 2^CSTEP bits (only when that cannot take the count below zero),
// and produces the step size and the decremented count.
//
// Ports:
//   cnt     in  CNTW  current remaining count
//   coarse  out 1     step is coarse (always 0 when CSTEP == 0)
//   stp     out CNTW  step size, 2^CSTEP or 1
//   cnt_nxt out CNTW  cnt - stp (only meaningful when cnt != 0)
module m_shiftstep #(
  parameter int unsigned CNTW  = 5,
  parameter int unsigned CSTEP = 0
) (
  input  logic [CNTW-1:0] cnt,
  output logic            coarse,
  output logic [CNTW-1:0] stp,
  output logic [CNTW-1:0] cnt_nxt
);

  localparam logic [CNTW-1:0] FineStp = CNTW'(1);

  if (CSTEP == 0) begin : g_fine_only
    // No coarse stepping: drop the compare entirely.
    assign coarse = 1'b0;
    assign stp    = FineStp;
  end else begin : g_coarse
    localparam logic [CNTW-1:0] CoarseStp = FineStp << CSTEP;
    // cnt >= 2^CSTEP is simply "any bit at or above CSTEP is set".
    assign coarse = |cnt[CNTW-1:CSTEP];
    assign stp    = coarse ? CoarseStp : FineStp;
  end

  assign cnt_nxt = cnt - stp;

endmodule

// File: rtl/m_shiftcounter_p.sv
// Parametrised shift-amount sequencer for the microcoded shifter.
//
// Holds the remaining shift distance of a shift instruction. Microcode loads
// it (directly from B, or as a byte offset scaled to bits), then advances it
// one step per cycle. Steps are 2^CSTEP bits while at least that much
// remains, then single bits. The count saturates at zero; advancing at zero
// sets a sticky underflow flag that is cleared by the next load.
//
// Parameters:
//   CNTW  : counter width, max distance 2^CNTW-1; needs CNTW >= BYTEW+3.
//   BYTEW : width of the byte-offset field used by the byte load.
//   CSTEP : log2 of the coarse step; 0 disables coarse stepping; < CNTW.
//
// Ports:
//   clk   : clock, rising edge.
//   rst_n : asynchronous active-low reset; clears count and uflow.
//   sh    : m_shiftcounter_p_if.slave bundle (s_shift, B in; busy, coarse,
//           lastshift, uflow, dbg_rshcnt out). Interface CNTW must match.
module m_shiftcounter_p
  import m_shiftpkg::*;
#(
  parameter int unsigned CNTW  = 5,
  parameter int unsigned BYTEW = 2,
  parameter int unsigned CSTEP = 0
) (
  input logic               clk,
  input logic               rst_n,
  m_shiftcounter_p_if.slave sh
);

  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            uflow_q, uflow_d;
  logic [CNTW-1:0] stp;
  logic [CNTW-1:0] cnt_dec;
  logic [CNTW-1:0] byte_cnt;
  logic            coarse;
  logic            busy;
  logic            adv;

  m_shiftstep #(
    .CNTW  (CNTW),
    .CSTEP (CSTEP)
  ) u_step (
    .cnt     (cnt_q),
    .coarse  (coarse),
    .stp     (stp),
    .cnt_nxt (cnt_dec)
  );

  assign busy     = (cnt_q != '0);
  assign adv      = (sh.s_shift == SH_ADV);
  // Byte offset to bit distance; upper bits of B are deliberately ignored.
  assign byte_cnt = CNTW'(sh.B[BYTEW-1:0]) << ByteShift;

  always_comb begin
    cnt_d   = cnt_q;
    uflow_d = uflow_q;
    unique case (sh.s_shift)
      SH_LOAD: begin
        cnt_d   = sh.B;
        uflow_d = 1'b0;
      end
      SH_LDBYTE: begin
        cnt_d   = byte_cnt;
        uflow_d = 1'b0;
      end
      SH_ADV: begin
        // Saturate at zero; the step decode never overshoots.
        if (busy) begin
          cnt_d = cnt_dec;
        end else begin
          uflow_d = 1'b1;
        end
      end
      SH_HOLD: begin
        cnt_d   = cnt_q;
        uflow_d = uflow_q;
      end
      default: begin
        cnt_d   = cnt_q;
        uflow_d = uflow_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      uflow_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      uflow_q <= uflow_d;
    end
  end

  assign sh.busy       = busy;
  assign sh.coarse     = coarse;
  // Decoded from the register in the request cycle so microcode can branch
  // on it with no added latency.
  assign sh.lastshift  = adv && busy && (cnt_q == stp);
  assign sh.uflow      = uflow_q;
  assign sh.dbg_rshcnt = cnt_q;

endmodule

// File: tb/tb_m_shiftcounter_p.sv
module tb_m_shiftcounter_p;

  localparam int unsigned CNTW  = 5;
  localparam int unsigned BYTEW = 2;

  logic clk;
  logic rst_n;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: index 0 is the CSTEP=0 instance, index 1 the CSTEP=2 one.
  int m_cnt [2];
  int m_uf  [2];
  int cstep [2] = '{0, 2};

  m_shiftcounter_p_if #(.CNTW(CNTW)) if0 ();
  m_shiftcounter_p_if #(.CNTW(CNTW)) if2 ();

  m_shiftcounter_p #(.CNTW(CNTW), .BYTEW(BYTEW), .CSTEP(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .sh    (if0)
  );

  m_shiftcounter_p #(.CNTW(CNTW), .BYTEW(BYTEW), .CSTEP(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .sh    (if2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int step_of(input int c, input int cs);
    if (cs > 0 && c >= (1 << cs)) return 1 << cs;
    return 1;
  endfunction

  function automatic logic exp_coarse(input int i);
    return cstep[i] > 0 && m_cnt[i] >= (1 << cstep[i]);
  endfunction

  function automatic logic exp_last(input int i, input int op);
    return op == 2 && m_cnt[i] != 0 && m_cnt[i] == step_of(m_cnt[i], cstep[i]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0;
      m_uf[i]  = 0;
    end
  endtask

  task automatic model_clock(input int op, input int b);
    for (int i = 0; i < 2; i++) begin
      case (op)
        0: begin m_cnt[i] = b; m_uf[i] = 0; end
        1: begin m_cnt[i] = (b % (1 << BYTEW)) * 8; m_uf[i] = 0; end
        2: begin
          if (m_cnt[i] == 0) m_uf[i] = 1;
          else m_cnt[i] = m_cnt[i] - step_of(m_cnt[i], cstep[i]);
        end
        default: ;
      endcase
    end
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, ".cnt0"},   32'(if0.dbg_rshcnt), 32'(m_cnt[0]));
    chk({tag, ".busy0"},  32'(if0.busy),       32'(m_cnt[0] != 0));
    chk({tag, ".uflow0"}, 32'(if0.uflow),      32'(m_uf[0]));
    chk({tag, ".cnt2"},   32'(if2.dbg_rshcnt), 32'(m_cnt[1]));
    chk({tag, ".busy2"},  32'(if2.busy),       32'(m_cnt[1] != 0));
    chk({tag, ".uflow2"}, 32'(if2.uflow),      32'(m_uf[1]));
  endtask

  // One cycle: drive at negedge, check combinational outputs, clock, check state.
  task automatic step(input string tag, input int op, input int b);
    @(negedge clk);
    if0.s_shift = 2'(op);
    if0.B       = CNTW'(b);
    if2.s_shift = 2'(op);
    if2.B       = CNTW'(b);
    #1;
    chk({tag, ".coarse0"}, 32'(if0.coarse),    32'(exp_coarse(0)));
    chk({tag, ".last0"},   32'(if0.lastshift), 32'(exp_last(0, op)));
    chk({tag, ".coarse2"}, 32'(if2.coarse),    32'(exp_coarse(1)));
    chk({tag, ".last2"},   32'(if2.lastshift), 32'(exp_last(1, op)));
    @(posedge clk);
    model_clock(op, b);
    #1;
    chk_regs(tag);
  endtask

  initial begin
    int op;
    rst_n       = 1'b0;
    if0.s_shift = 2'b11;
    if0.B       = '0;
    if2.s_shift = 2'b11;
    if2.B       = '0;
    model_reset();
    #3;
    chk_regs("reset");
    chk("reset.coarse2", 32'(if2.coarse), 32'd0);
    chk("reset.last2",   32'(if2.lastshift), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load 3, three single steps.
    step("ld3", 0, 3);
    for (int k = 0; k < 3; k++) step("adv3", 2, 0);
    chk("ld3.end", 32'(if0.dbg_rshcnt), 32'd0);

    // Load 13: coarse steps 13,9,5,1 then fine on the CSTEP=2 instance.
    step("ld13", 0, 13);
    for (int k = 0; k < 5; k++) step("adv13", 2, 0);

    // Byte loads.
    step("ldb3", 1, 5'b10111);
    chk("ldb3.val", 32'(if0.dbg_rshcnt), 32'd24);
    for (int k = 0; k < 3; k++) step("advb", 2, 0);
    step("ldb0", 1, 5'b11100);
    step("advb0", 2, 0);

    // Load 0, advance underflows, load 5 clears uflow.
    step("ld0", 0, 0);
    step("adv0", 2, 0);
    chk("adv0.uf", 32'(if2.uflow), 32'd1);
    step("ld5", 0, 5);

    // Load overriding a running count, then hold.
    step("ld2", 0, 2);
    step("ld7", 0, 7);
    step("advh", 2, 0);
    for (int k = 0; k < 4; k++) step("hold", 3, 0);
    step("advh2", 2, 0);

    // Asynchronous reset mid-count.
    step("ld9", 0, 9);
    step("adv9", 2, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_regs("arst");
    @(negedge clk);
    rst_n = 1'b1;
    step("arst.adv", 2, 0);
    chk("arst.uf", 32'(if0.uflow), 32'd1);

    // Random ops, biased toward advancing.
    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 9))
        0, 1:    op = 0;
        2:       op = 1;
        3:       op = 3;
        default: op = 2;
      endcase
      step("rnd", op, int'($urandom_range(0, 31)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/m_shiftcounter_p.md
# m_shiftcounter_p

Parametrised shift-amount sequencer for midgetv's microcoded shifter; successor to the fixed 5-bit shift counter. Holds the remaining shift distance for a shift instruction, optionally consumes it in coarse steps of 2^CSTEP bits before single-bit steps, and tells microcode which step size to apply and when the final step occurs. Unlike its predecessor it saturates at zero instead of wrapping, flags underflow, and has an asynchronous reset.

## Interface
- CNTW, 5: counter width; maximum shift distance 2^CNTW-1. Must satisfy CNTW >= BYTEW+3.
- BYTEW, 2: width of the byte-offset field used by byte-load mode.
- CSTEP, 0: log2 of the coarse step size; 0 disables coarse stepping. Must satisfy CSTEP < CNTW.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- s_shift  in  2  operation: 00 load B; 01 load byte offset; 10 advance; 11 hold.
- B  in  CNTW  load source.
- busy  out  1  registered: remaining count != 0.
- coarse  out  1  combinational: current step is coarse (CSTEP>0 and count >= 2^CSTEP).
- lastshift  out  1  combinational: this advance consumes the remaining count.
- uflow  out  1  registered sticky: an advance was issued with count 0.
- dbg_rshcnt  out  CNTW  registered remaining count.

## Operation
- Register cnt[CNTW-1:0]. Step size stp = 2^CSTEP when coarse, else 1.
- 00: cnt <= B. uflow <= 0.
- 01: cnt <= {B[BYTEW-1:0], 3'b000}, zero-extended to CNTW. uflow <= 0. Bits B[CNTW-1:BYTEW] ignored.
- 10, cnt != 0: cnt <= cnt - stp. Never crosses zero: coarse only when cnt >= 2^CSTEP.
- 10, cnt == 0: cnt holds 0; uflow <= 1.
- 11: all state holds.
- busy = (cnt != 0).
- lastshift = s_shift==10 and cnt != 0 and cnt == stp. It is never asserted in a load cycle or for an advance at 0.
- Implicit two-state view: IDLE (cnt==0) and RUN (cnt!=0). A load of 0 goes directly to IDLE. In that case microcode must test busy and skip the shift loop.
- Steps for distance N: (N >> CSTEP) + (N mod 2^CSTEP). With CSTEP=0 this is N.
- A load issued while RUN overrides the current count. There is no interlock.

## Timing
- Reset, asynchronous on rst_n low: cnt=0, uflow=0, hence busy=0, coarse=0, lastshift=0, dbg_rshcnt=0.
- Reset release: the first clock edge with rst_n high is the first active edge.
- Load takes effect at the next edge. busy and coarse reflect the loaded value one cycle after the load cycle.
- lastshift and coarse are valid in the same cycle as the advance request, decoded from the register. The microcode step is therefore zero-latency.
- Reset asserted mid-sequence: the count is abandoned immediately and the block returns to IDLE.

## Structure
- Shared package m_shiftpkg holds:
  - op encodings SH_LOAD=2'b00, SH_LDBYTE=2'b01, SH_ADV=2'b10, SH_HOLD=2'b11;
  - the byte-shift constant 3 used for byte-offset scaling.
- One sub-module m_shiftstep: purely combinational. Takes cnt and CSTEP; produces coarse, stp and cnt-stp. It is shared with the future funnel-shift sequencer.
- The top holds the op decode, the cnt/uflow registers with async clear, and the output decode.
- Generate guard: when CSTEP=0, coarse is tied to 0 and the m_shiftstep compare is removed.

## Test plan
- Reset: rst_n low mid-RUN with cnt=9 -> immediately cnt=0, busy=0, uflow=0; after release an advance sets uflow=1.
- CNTW=5, CSTEP=0, load B=3, advance x3 -> dbg_rshcnt 3,2,1,0; lastshift only on the 3rd advance; busy falls after the 3rd edge.
- CSTEP=2, load 13, advance -> coarse=1,1,1,0; counts 13,9,5,1,0; lastshift on the 4th advance only.
- Byte load, B[1:0]=2'b11 (CNTW=5) -> cnt=24. Byte load with B[1:0]=0 -> cnt=0, busy=0, lastshift never asserted.
- Load B=0 then advance -> cnt stays 0, uflow=1, lastshift=0. A subsequent load of 5 clears uflow.
- Simultaneous events: load of 7 issued while cnt=2 -> next cnt=7, no lastshift in the load cycle. Hold (11) for 4 cycles mid-count -> cnt and flags unchanged.
